// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V memory coalescer: element width, FSM state and
// byte-mask helpers derived from the element width.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } vsew_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] eew_byte_mask(input vsew_t e);
        case (e)
            SEW8:    return 4'b0001;
            SEW16:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] eew_bit_mask(input vsew_t e);
        logic [3:0] m;
        m = eew_byte_mask(e);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Low address bits that must be zero for a naturally aligned element.
    function automatic logic [1:0] eew_align_mask(input vsew_t e);
        case (e)
            SEW8:    return 2'b00;
            SEW16:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/rv32v_lane_grouper.sv
// Picks the lowest pending lane as leader and the lanes sharing its word.
// RV32V_MEM_COALESCE_EN: when undefined the group is the leader alone.
module rv32v_lane_grouper
    import rv32v_types_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0]         pending,
    input  logic [NUM_LANES-1:0][31:0]   addr,
    input  vsew_t                        eew,
    output logic [$clog2(NUM_LANES)-1:0] leader,
    output logic [NUM_LANES-1:0]         group
);
    logic found;
    logic unused_inputs;

    // Aligned elements never straddle a word, so width plays no part here.
    assign unused_inputs = ^{eew, addr};

    always_comb begin
        leader = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pending[i] && !found) begin
                leader = ($clog2(NUM_LANES))'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        group = '0;
`ifdef RV32V_MEM_COALESCE_EN
        for (int i = 0; i < NUM_LANES; i++) begin
            group[i] = found && pending[i] && (addr[i][31:2] == addr[leader][31:2]);
        end
`else
        group[leader] = found;
`endif
    end

endmodule

// File: rtl/rv32v_mem_coalescer.sv
// Turns one vector load/store micro-op into word accesses on the LSC port,
// merging same-word lanes when RV32V_MEM_COALESCE_EN is defined.
module rv32v_mem_coalescer
    import rv32v_types_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int WORD_BYTES = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       vmemdren,
    input  logic                       vmemdwen,
    input  vsew_t                      veew,
    input  logic [NUM_LANES-1:0]       vlane_mask,
    input  logic [NUM_LANES-1:0][31:0] vlane_addr,
    input  logic [NUM_LANES-1:0][31:0] vlane_store_data,
    input  logic                       lsc_ready,
    input  logic [31:0]                lsc_load_data,
    output logic                       lsc_ren,
    output logic                       lsc_wen,
    output logic [31:0]                lsc_addr,
    output logic [3:0]                 lsc_byte_en,
    output logic [31:0]                lsc_store_data,
    output logic [NUM_LANES-1:0][31:0] vlane_load_data,
    output logic [NUM_LANES-1:0]       vlane_load_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       misaligned
);
    localparam int IW = $clog2(NUM_LANES);
    localparam int OW = $clog2(WORD_BYTES);

    state_t                     state_q, state_d;
    logic [NUM_LANES-1:0]       pending_q, pending_d;
    logic                       store_q, store_d;
    vsew_t                      eew_q, eew_d;
    logic [NUM_LANES-1:0][31:0] addr_q, addr_d;
    logic [NUM_LANES-1:0][31:0] sdata_q, sdata_d;
    logic                       mis_q, mis_d;
    logic [NUM_LANES-1:0][31:0] ld_data_q, ld_data_d;
    logic [NUM_LANES-1:0]       ld_valid_q, ld_valid_d;

    logic [IW-1:0]        leader;
    logic [NUM_LANES-1:0] group;
    logic                 issuing;
    logic                 start_mis;
    logic [3:0]           be_acc;
    logic [31:0]          wdata;

    rv32v_lane_grouper #(.NUM_LANES(NUM_LANES)) u_grouper (
        .pending (pending_q),
        .addr    (addr_q),
        .eew     (eew_q),
        .leader  (leader),
        .group   (group)
    );

    always_comb begin
        start_mis = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (vlane_mask[i] && ((vlane_addr[i][1:0] & eew_align_mask(veew)) != 2'b00))
                start_mis = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        store_d    = store_q;
        eew_d      = eew_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        mis_d      = 1'b0;
        ld_data_d  = ld_data_q;
        ld_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (vmemdren || vmemdwen) begin
                    store_d = vmemdwen;
                    eew_d   = veew;
                    addr_d  = vlane_addr;
                    sdata_d = vlane_store_data;
                    if (start_mis) begin
                        mis_d     = 1'b1;
                        pending_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        pending_d = vlane_mask;
                        state_d   = (vlane_mask == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (lsc_ready) begin
                    pending_d = pending_q & ~group;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (group[i] && !store_q) begin
                            ld_data_d[i]  = (lsc_load_data >> {addr_q[i][OW-1:0], 3'b000})
                                            & eew_bit_mask(eew_q);
                            ld_valid_d[i] = 1'b1;
                        end
                    end
                    if ((pending_q & ~group) == '0) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lanes are merged in ascending order so a higher lane overwrites overlaps.
    always_comb begin
        logic [3:0]  lane_be;
        logic [31:0] lane_dat;
        lane_be  = '0;
        lane_dat = '0;
        be_acc   = '0;
        wdata    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (group[i]) begin
                lane_be  = 4'(eew_byte_mask(eew_q) << addr_q[i][OW-1:0]);
                lane_dat = sdata_q[i] << {addr_q[i][OW-1:0], 3'b000};
                be_acc   = be_acc | lane_be;
                for (int b = 0; b < 4; b++) begin
                    if (lane_be[b]) wdata[8*b +: 8] = lane_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            store_q    <= 1'b0;
            eew_q      <= SEW8;
            addr_q     <= '0;
            sdata_q    <= '0;
            mis_q      <= 1'b0;
            ld_data_q  <= '0;
            ld_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            store_q    <= store_d;
            eew_q      <= eew_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            mis_q      <= mis_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
        end
    end

    assign issuing          = (state_q == ST_ISSUE);
    assign lsc_ren          = issuing && !store_q;
    assign lsc_wen          = issuing && store_q;
    assign lsc_addr         = issuing ? {addr_q[leader][31:2], 2'b00} : '0;
    assign lsc_byte_en      = issuing ? be_acc : '0;
    assign lsc_store_data   = lsc_wen ? wdata : '0;
    assign vlane_load_data  = ld_data_q;
    assign vlane_load_valid = ld_valid_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign misaligned       = mis_q;

endmodule
